// File: rtl/register_bank_pkg.sv
// Shared types and default widths for the general-purpose register bank.
package register_bank_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DUMP = 2'd1,
      ST_DONE = 2'd2
   } dump_state_e;

endpackage : register_bank_pkg

// File: rtl/register_bank_if.sv
// Read, write and dump-stream signals of the register bank.
interface register_bank_if import register_bank_pkg::*; #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic [ADDR_W-1:0] reg_read_1;
   logic [ADDR_W-1:0] reg_read_2;
   logic [ADDR_W-1:0] reg_write;
   logic              reg_write_signal;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] out_data_1;
   logic [DATA_W-1:0] out_data_2;
   logic              dump_start;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_index;
   logic [DATA_W-1:0] dump_data;
   logic              dump_busy;
   logic              dump_done;

   modport master (
      output reg_read_1, reg_read_2, reg_write, reg_write_signal, in_data,
      output dump_start, dump_ready,
      input  out_data_1, out_data_2,
      input  dump_valid, dump_index, dump_data, dump_busy, dump_done
   );

   modport slave (
      input  reg_read_1, reg_read_2, reg_write, reg_write_signal, in_data,
      input  dump_start, dump_ready,
      output out_data_1, out_data_2,
      output dump_valid, dump_index, dump_data, dump_busy, dump_done
   );

endinterface : register_bank_if

// File: rtl/register_dump_ctrl.sv
// Dump sequencer: walks every register index once under a valid/ready handshake.
module register_dump_ctrl import register_bank_pkg::*; #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_index,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_busy,
   output logic              dump_done
);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // The last index is all-ones, so leaving DUMP there makes pointer wrap impossible.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (dump_start) begin
               state_d = ST_DUMP;
               ptr_d   = '0;
            end
         end
         ST_DUMP: begin
            if (dump_ready) begin
               if (ptr_q == '1) state_d = ST_DONE;
               else             ptr_d   = ptr_q + ADDR_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_addr    = ptr_q;
   assign dump_valid = (state_q == ST_DUMP);
   assign dump_busy  = (state_q != ST_IDLE);
   assign dump_done  = (state_q == ST_DONE);
   assign dump_index = ptr_q;
   assign dump_data  = dump_valid ? rd_data : '0;

endmodule : register_dump_ctrl

// File: rtl/register_bank.sv
// Register array with two bypassed combinational read ports, one write port and a dump stream.
module register_bank import register_bank_pkg::*; #(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1
) (
   input logic             clk,
   input logic             rst,
   register_bank_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              wr_en_c;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_rd_data;
   logic [DATA_W-1:0] rd_1, rd_2;

   assign wr_en_c = bus.reg_write_signal && !(ZERO_REG && (bus.reg_write == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (wr_en_c) begin
         regs_q[bus.reg_write] <= bus.in_data;
      end
   end

   // Zero register beats bypass, bypass beats storage.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              we,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      if (ZERO_REG && (addr == '0))  return '0;
      else if (we && (waddr == addr)) return wdata;
      else                            return stored;
   endfunction

   always_comb begin
      rd_1 = read_port(bus.reg_read_1, regs_q[bus.reg_read_1], bus.reg_write_signal,
                       bus.reg_write, bus.in_data);
      rd_2 = read_port(bus.reg_read_2, regs_q[bus.reg_read_2], bus.reg_write_signal,
                       bus.reg_write, bus.in_data);
   end

   assign bus.out_data_1 = rd_1;
   assign bus.out_data_2 = rd_2;

   // Dump sees stored state only, no write bypass.
   assign dump_rd_data = (ZERO_REG && (dump_addr == '0)) ? '0 : regs_q[dump_addr];

   register_dump_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dump_ctrl (
      .clk        (clk),
      .rst        (rst),
      .dump_start (bus.dump_start),
      .dump_ready (bus.dump_ready),
      .rd_addr    (dump_addr),
      .rd_data    (dump_rd_data),
      .dump_valid (bus.dump_valid),
      .dump_index (bus.dump_index),
      .dump_data  (bus.dump_data),
      .dump_busy  (bus.dump_busy),
      .dump_done  (bus.dump_done)
   );

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Bench for register_bank: one instance with the zero register, one without, driven in lockstep.
module tb_register_bank;

   logic       clk;
   logic       rst;
   logic [2:0] r1, r2, wa;
   logic       we;
   logic [7:0] din;
   logic       start, ready;

   logic [7:0] mz [8];
   logic [7:0] mn [8];

   int checks   = 0;
   int failures = 0;

   register_bank_if #(.DATA_W(8), .ADDR_W(3)) bz ();
   register_bank_if #(.DATA_W(8), .ADDR_W(3)) bn ();

   assign bz.reg_read_1 = r1;  assign bn.reg_read_1 = r1;
   assign bz.reg_read_2 = r2;  assign bn.reg_read_2 = r2;
   assign bz.reg_write  = wa;  assign bn.reg_write  = wa;
   assign bz.reg_write_signal = we;  assign bn.reg_write_signal = we;
   assign bz.in_data    = din; assign bn.in_data    = din;
   assign bz.dump_start = start; assign bn.dump_start = start;
   assign bz.dump_ready = ready; assign bn.dump_ready = ready;

   register_bank #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut_z (
      .clk (clk), .rst (rst), .bus (bz)
   );
   register_bank #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut_n (
      .clk (clk), .rst (rst), .bus (bn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference read: zero register, then pending write, then stored contents.
   function automatic logic [7:0] exp_rd(input bit zero, input logic [2:0] a);
      if (zero && a == 3'd0) return 8'h00;
      if (we && wa == a)     return din;
      return zero ? mz[a] : mn[a];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin mz[i] = 8'h00; mn[i] = 8'h00; end
      end else if (we) begin
         if (wa != 3'd0) mz[wa] = din;
         mn[wa] = din;
      end
      #1;
   endtask

   task automatic chk_reads(input string tag);
      chk({tag, "_z1"}, 32'(bz.out_data_1), 32'(exp_rd(1'b1, r1)));
      chk({tag, "_z2"}, 32'(bz.out_data_2), 32'(exp_rd(1'b1, r2)));
      chk({tag, "_n1"}, 32'(bn.out_data_1), 32'(exp_rd(1'b0, r1)));
      chk({tag, "_n2"}, 32'(bn.out_data_2), 32'(exp_rd(1'b0, r2)));
   endtask

   task automatic chk_status(input string tag, input bit v, input bit b, input bit d);
      chk({tag, "_valid_z"}, 32'(bz.dump_valid), 32'(v));
      chk({tag, "_busy_z"},  32'(bz.dump_busy),  32'(b));
      chk({tag, "_done_z"},  32'(bz.dump_done),  32'(d));
      chk({tag, "_valid_n"}, 32'(bn.dump_valid), 32'(v));
      chk({tag, "_busy_n"},  32'(bn.dump_busy),  32'(b));
      chk({tag, "_done_n"},  32'(bn.dump_done),  32'(d));
   endtask

   task automatic chk_word(input string tag, input logic [2:0] idx);
      chk({tag, "_idx_z"},  32'(bz.dump_index), 32'(idx));
      chk({tag, "_idx_n"},  32'(bn.dump_index), 32'(idx));
      chk({tag, "_data_z"}, 32'(bz.dump_data),  32'(mz[idx]));
      chk({tag, "_data_n"}, 32'(bn.dump_data),  32'(mn[idx]));
   endtask

   initial begin
      bit found, done_seen, wrote;
      int exp_idx;

      for (int i = 0; i < 8; i++) begin mz[i] = 8'h00; mn[i] = 8'h00; end
      rst = 1'b1; r1 = '0; r2 = '0; wa = 3'd3; we = 1'b1; din = 8'hA5;
      start = 1'b0; ready = 1'b0;

      // Reset, with a write to r3 that must lose to reset.
      tick();
      tick();
      @(negedge clk);
      chk_status("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_idx_z", 32'(bz.dump_index), 32'd0);
      chk("rst_data_z", 32'(bz.dump_data), 32'd0);
      chk("rst_data_n", 32'(bn.dump_data), 32'd0);
      tick();
      rst = 1'b0; we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         r1 = 3'(i); r2 = 3'(7 - i);
         @(negedge clk);
         chk_reads("rst_read");
         tick();
      end
      r1 = 3'd3;
      @(negedge clk);
      chk("rst_r3_z", 32'(bz.out_data_1), 32'd0);
      chk("rst_r3_n", 32'(bn.out_data_1), 32'd0);
      tick();

      // Same-cycle bypass, then storage.
      we = 1'b1; wa = 3'd5; din = 8'h3C; r1 = 3'd5; r2 = 3'd2;
      @(negedge clk);
      chk("bypass_z", 32'(bz.out_data_1), 32'h3C);
      chk("bypass_n", 32'(bn.out_data_1), 32'h3C);
      tick();
      we = 1'b0; r1 = 3'd5; r2 = 3'd5;
      @(negedge clk);
      chk("stored_z1", 32'(bz.out_data_1), 32'h3C);
      chk("stored_z2", 32'(bz.out_data_2), 32'h3C);
      chk("stored_n2", 32'(bn.out_data_2), 32'h3C);
      tick();

      // Register 0: hardwired in one instance, ordinary in the other.
      we = 1'b1; wa = 3'd0; din = 8'hFF; r1 = 3'd0; r2 = 3'd0;
      @(negedge clk);
      chk("r0_wcyc_z", 32'(bz.out_data_1), 32'h00);
      chk("r0_wcyc_n", 32'(bn.out_data_1), 32'hFF);
      tick();
      we = 1'b0;
      @(negedge clk);
      chk("r0_after_z", 32'(bz.out_data_2), 32'h00);
      chk("r0_after_n", 32'(bn.out_data_2), 32'hFF);
      tick();

      // Random reads and writes against the reference contents.
      for (int n = 0; n < 200; n++) begin
         r1 = 3'($urandom_range(0, 7)); r2 = 3'($urandom_range(0, 7));
         wa = 3'($urandom_range(0, 7)); we = 1'($urandom_range(0, 1));
         din = 8'($urandom);
         @(negedge clk);
         chk_reads("rand");
         tick();
      end

      // Load rN = N*0x11.
      for (int n = 0; n < 8; n++) begin
         we = 1'b1; wa = 3'(n); din = 8'(n * 17);
         @(negedge clk);
         tick();
      end
      we = 1'b0;

      // Dump with ready held high; start held during busy must be ignored.
      start = 1'b1; ready = 1'b1;
      @(negedge clk);
      chk_status("d1_pre", 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk_status("d1_word", 1'b1, 1'b1, 1'b0);
         chk_word("d1", 3'(i));
         chk("d1_const", 32'(bz.dump_data), 32'(8'(i * 17)));
         tick();
      end
      start = 1'b0;
      @(negedge clk);
      chk_status("d1_done", 1'b0, 1'b1, 1'b1);
      tick();
      @(negedge clk);
      chk_status("d1_idle", 1'b0, 1'b0, 1'b0);
      tick();

      // Dump with ready toggling and a write to the held index.
      start = 1'b1; ready = 1'b0;
      @(negedge clk);
      tick();
      start = 1'b0;
      exp_idx = 0; wrote = 1'b0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 48 && !done_seen; cyc++) begin
         ready = cyc[0];
         we = bz.dump_valid && !ready && (bz.dump_index == 3'd2) && !wrote;
         wa = 3'd2; din = 8'h99;
         @(negedge clk);
         if (bz.dump_done) begin
            done_seen = 1'b1;
            chk_status("d2_done", 1'b0, 1'b1, 1'b1);
            chk("d2_count", 32'(exp_idx), 32'd8);
         end else begin
            chk_status("d2_word", 1'b1, 1'b1, 1'b0);
            chk_word("d2", 3'(exp_idx));
            if (wrote && exp_idx == 2) chk("d2_held99", 32'(bz.dump_data), 32'h99);
            if (ready) exp_idx++;
         end
         tick();
         if (we) wrote = 1'b1;
      end
      we = 1'b0; ready = 1'b1;
      chk("d2_finished", 32'(done_seen), 32'd1);
      chk("d2_wrote", 32'(wrote), 32'd1);

      // Reset while index 4 is presented.
      @(negedge clk);
      tick();
      start = 1'b1;
      @(negedge clk);
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (bz.dump_valid && bz.dump_index == 3'd4) found = 1'b1;
         else tick();
      end
      chk("d3_reached4", 32'(found), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_status("d3_after_rst", 1'b0, 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         r1 = 3'(i); r2 = 3'(i);
         @(negedge clk);
         chk_reads("d3_zeroed");
         chk("d3_zero_n", 32'(bn.out_data_1), 32'd0);
         tick();
      end
      start = 1'b1;
      @(negedge clk);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk_status("d3_fresh", 1'b1, 1'b1, 1'b0);
      chk_word("d3_fresh", 3'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_register_bank

// File: doc/register_bank.md
# register_bank

Parametrised successor to the single-cycle MIPS register file: a general-purpose register array of configurable width and depth, with two combinational read ports, one clocked write port, an optional hardwired zero register and same-cycle write-to-read bypass. It also has a handshaked dump port that streams every register out in index order, which is how the testbench and debug logic observe architectural state. It sits between instruction decode (read addresses) and writeback (write port) in the datapath.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers (derived, not overridable)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_read_1  in  ADDR_W  read port 1 address
- reg_read_2  in  ADDR_W  read port 2 address
- reg_write  in  ADDR_W  write address
- reg_write_signal  in  1  write enable
- in_data  in  DATA_W  write data
- out_data_1  out  DATA_W  read port 1 data (combinational)
- out_data_2  out  DATA_W  read port 2 data (combinational)
- dump_start  in  1  request a full-array dump (sampled in IDLE only)
- dump_valid  out  1  dump_index/dump_data are valid
- dump_ready  in  1  consumer accepts current dump word
- dump_index  out  ADDR_W  index of word being presented
- dump_data  out  DATA_W  stored value of register dump_index
- dump_busy  out  1  high in DUMP and DONE states
- dump_done  out  1  one-cycle pulse after final word accepted

## Operation
- Write: on posedge with reg_write_signal=1 and rst=0, registers[reg_write] <= in_data; dropped if ZERO_REG=1 and reg_write=0.
- Read port n: if ZERO_REG=1 and address=0 -> 0; else if reg_write_signal=1 and reg_write=address -> in_data (bypass); else stored value. Both ports independent; same address on both allowed.
- Reset: all registers <= 0, FSM <= IDLE, dump pointer <= 0. Reset wins over a simultaneous write.
- Dump FSM states:
  - IDLE: dump_valid=0, dump_busy=0; dump_start=1 -> DUMP, pointer <= 0.
  - DUMP: dump_valid=1, dump_index=pointer, dump_data=stored registers[pointer] (no bypass; register 0 reads 0 when ZERO_REG=1). On dump_valid&dump_ready: if pointer=DEPTH-1 -> DONE, else pointer+1. Without ready, index and state hold; dump_data tracks any write to that register.
  - DONE: dump_done=1, dump_valid=0 for one cycle -> IDLE.
- dump_start outside IDLE ignored (no queuing). Normal reads and writes are unaffected by dump activity.
- Reset mid-dump: next cycle IDLE, outputs deasserted, no dump_done.

## Timing
- Reset values: dump_valid=0, dump_busy=0, dump_done=0, dump_index=0, dump_data=0. out_data_* reflect combinationally zeroed contents.
- Write latency: visible on read ports in the same cycle via bypass, from storage after the edge.
- dump_start at edge k -> dump_valid from cycle k+1, index 0. With dump_ready held high, indices 0..DEPTH-1 appear on cycles k+1..k+DEPTH, dump_done in cycle k+DEPTH+1, IDLE at k+DEPTH+2. A new start is accepted at edge k+DEPTH+2 at the earliest.
- Pointer wrap not possible: leaves DUMP at DEPTH-1.

## Structure
- Shared package: dump FSM state enum (IDLE, DUMP, DONE) and default DATA_W/ADDR_W constants used by the datapath.
- One natural sub-module: register_dump_ctrl, holding the FSM and pointer, with a read address out and data in. The array and read/bypass logic stay in register_bank.

## Test plan
- Reset then read all addresses -> every out_data_* = 0; write 0xA5 to r3 with rst=1 -> r3 still 0 afterwards.
- Write 0x3C to r5 and read r5 on port 1 in the same cycle -> out_data_1=0x3C (bypass); next cycle read r5 on both ports -> 0x3C on both.
- ZERO_REG=1: write 0xFF to r0 -> r0 reads 0, including in the write cycle. ZERO_REG=0: same write -> reads 0xFF.
- Load rN=N*0x11, then dump with ready high -> indices 0..7 with data 0x00..0x77 (r0=0) over 8 consecutive cycles, dump_done pulse, dump_start during busy ignored.
- Dump with ready toggling every other cycle plus a write of 0x99 to the currently held index -> index holds, dump_data shows 0x99 before acceptance, and each index is transferred exactly once.
- Assert rst at index 4 of a dump -> IDLE next cycle, no dump_done, all registers 0; a fresh dump then starts at index 0.
